tcp_con_mgr: RTL and testbench

User-side driver of the TCP control interface. It drives the `out` modport of `tcp_ctl_ifc` (connect, listen, rem_ipv4, rem_port, loc_port) and monitors the engine's status, con_ipv4 and con_port. It runs client connect or server listen, with attempt timeout, retry back-off, a retry limit and automatic re-arm after the connection drops. It sits between application logic and the TCP engine, one instance per TCP engine.

---
 rtl/tcp_vlg_pkg.sv | 40 ++++
 rtl/tcp_ctl_ifc.sv | 31 +++
 rtl/tcp_con_tmr.sv | 38 +++
 rtl/tcp_con_mgr.sv | 213 +++++++++++++++++++++
 tb/tb_tcp_con_mgr.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tcp_vlg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tcp_vlg_pkg
// Description : Shared types for the TCP engine control path: address/port
//               types, engine status codes and the connection-manager
//               FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package tcp_vlg_pkg;

  typedef logic [31:0] ipv4_t;
  typedef logic [15:0] port_t;

  // Engine connection status as reported on the control interface.
  typedef enum logic [3:0] {
    tcp_closed       = 4'd0,
    tcp_listen       = 4'd1,
    tcp_syn_sent     = 4'd2,
    tcp_syn_received = 4'd3,
    tcp_established  = 4'd4,
    tcp_fin_wait_1   = 4'd5,
    tcp_fin_wait_2   = 4'd6,
    tcp_close_wait   = 4'd7,
    tcp_closing      = 4'd8,
    tcp_last_ack     = 4'd9,
    tcp_time_wait    = 4'd10
  } tcp_stat_t;

  // Connection manager states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    WAIT    = 3'd2,
    UP      = 3'd3,
    BACKOFF = 3'd4,
    HOLD    = 3'd5
  } con_mgr_fsm_t;

endpackage
`default_nettype wire

// File: rtl/tcp_ctl_ifc.sv
`default_nettype none
// ============================================================================
// Module      : tcp_ctl_ifc
// Description : Control interface between user logic and a TCP engine.
//               out : user side (drives requests, reads status/peer)
//               in  : engine side
// Revision    : 1.0 - initial release
// ============================================================================
interface tcp_ctl_ifc;
  import tcp_vlg_pkg::*;

  logic      connect;
  logic      listen;
  ipv4_t     rem_ipv4;
  port_t     rem_port;
  port_t     loc_port;
  tcp_stat_t status;
  ipv4_t     con_ipv4;
  port_t     con_port;

  modport out (
    output connect, listen, rem_ipv4, rem_port, loc_port,
    input  status, con_ipv4, con_port
  );

  modport in (
    input  connect, listen, rem_ipv4, rem_port, loc_port,
    output status, con_ipv4, con_port
  );
endinterface
`default_nettype wire

// File: rtl/tcp_con_tmr.sv
`default_nettype none
// ============================================================================
// Module      : tcp_con_tmr
// Description : Loadable down-counter with a done flag. Shared between the
//               attempt-timeout and back-off phases of tcp_con_mgr.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               load_i          - load load_val_i this cycle
//               load_val_i      - value to load (ticks - 1)
//               done_o          - counter has reached zero
// Revision    : 1.0 - initial release
// ============================================================================
module tcp_con_tmr #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q;

  // Stops at zero, so it never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign done_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/tcp_con_mgr.sv
`default_nettype none
// ============================================================================
// Module      : tcp_con_mgr
// Description : User-side driver of the TCP control interface. Runs client
//               connect or server listen with attempt timeout, retry
//               back-off, a retry limit and automatic re-arm on drop.
// Ports       : clk, rst                 - clock, sync active-high reset
//               en                       - 1 = manage connection
//               server                   - 1 = listen, 0 = connect
//               cfg_rem_ipv4/rem_port    - client target
//               cfg_loc_port             - local port
//               ctl                      - control interface to the engine
//               connected                - link is up
//               peer_ipv4/peer_port      - peer captured on link up
//               attempts                 - attempts since leaving IDLE
//               give_up                  - retry limit reached (sticky)
// Revision    : 1.0 - initial release
// ============================================================================
module tcp_con_mgr
  import tcp_vlg_pkg::*;
#(
  parameter int TIMEOUT_TICKS = 1250000,
  parameter int BACKOFF_TICKS = 125000,
  parameter int MAX_RETRIES   = 0,
  parameter int CNT_W         = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          server,
  input  ipv4_t         cfg_rem_ipv4,
  input  port_t         cfg_rem_port,
  input  port_t         cfg_loc_port,
  tcp_ctl_ifc.out       ctl,
  output logic          connected,
  output ipv4_t         peer_ipv4,
  output port_t         peer_port,
  output logic [7:0]    attempts,
  output logic          give_up
);

  localparam logic [CNT_W-1:0] c_tmo_load = CNT_W'(TIMEOUT_TICKS - 1);
  localparam logic [CNT_W-1:0] c_bko_load = CNT_W'(BACKOFF_TICKS - 1);

  con_mgr_fsm_t state_q, state_d;
  logic         server_q, server_d;
  ipv4_t        rem_ipv4_q, rem_ipv4_d;
  port_t        rem_port_q, rem_port_d;
  port_t        loc_port_q, loc_port_d;
  logic         connect_q, connect_d;
  logic         listen_q, listen_d;
  logic         connected_q, connected_d;
  ipv4_t        peer_ipv4_q, peer_ipv4_d;
  port_t        peer_port_q, peer_port_d;
  logic [7:0]   attempts_q, attempts_d;
  logic         give_up_q, give_up_d;
  // Engine has left tcp_closed during this attempt; a later return to
  // closed means the attempt was refused.
  logic         seen_open_q, seen_open_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_done;

  tcp_con_tmr #(.CNT_W(CNT_W)) u_tmr (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  always_comb begin
    state_d     = state_q;
    server_d    = server_q;
    rem_ipv4_d  = rem_ipv4_q;
    rem_port_d  = rem_port_q;
    loc_port_d  = loc_port_q;
    peer_ipv4_d = peer_ipv4_q;
    peer_port_d = peer_port_q;
    attempts_d  = attempts_q;
    give_up_d   = give_up_q;
    seen_open_d = seen_open_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;

    case (state_q)
      IDLE: begin
        if (en && ctl.status == tcp_closed) begin
          server_d   = server;
          rem_ipv4_d = cfg_rem_ipv4;
          rem_port_d = cfg_rem_port;
          loc_port_d = cfg_loc_port;
          attempts_d = 8'd1;
          state_d    = ARM;
        end
      end

      ARM: begin
        tmr_load    = 1'b1;
        tmr_val     = c_tmo_load;
        seen_open_d = 1'b0;
        state_d     = WAIT;
      end

      WAIT: begin
        if (ctl.status != tcp_closed) begin
          seen_open_d = 1'b1;
        end
        // Established is tested first so it wins over a same-cycle timeout.
        if (ctl.status == tcp_established) begin
          peer_ipv4_d = ctl.con_ipv4;
          peer_port_d = ctl.con_port;
          state_d     = UP;
        end else if (!server_q &&
                     (tmr_done || (seen_open_q && ctl.status == tcp_closed))) begin
          tmr_load = 1'b1;
          tmr_val  = c_bko_load;
          state_d  = BACKOFF;
        end
      end

      UP: begin
        if (ctl.status != tcp_established) begin
          tmr_load = 1'b1;
          tmr_val  = c_bko_load;
          state_d  = BACKOFF;
        end
      end

      BACKOFF: begin
        if (tmr_done) begin
          if (MAX_RETRIES != 0 && int'(attempts_q) >= MAX_RETRIES) begin
            give_up_d = 1'b1;
            state_d   = HOLD;
          end else if (ctl.status == tcp_closed) begin
            if (attempts_q != 8'hFF) begin
              attempts_d = attempts_q + 8'd1;
            end
            state_d = ARM;
          end
        end
      end

      HOLD: begin
        state_d = HOLD;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Releasing en overrides every event seen this cycle.
    if (!en) begin
      state_d    = IDLE;
      attempts_d = 8'd0;
      give_up_d  = 1'b0;
    end

    // Request levels are held through WAIT and UP; the ARM cycle itself
    // is where the level gets registered.
    connect_d   = !server_q && (state_d == WAIT || state_d == UP);
    listen_d    =  server_q && (state_d == WAIT || state_d == UP);
    connected_d = (state_d == UP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      server_q    <= 1'b0;
      rem_ipv4_q  <= '0;
      rem_port_q  <= '0;
      loc_port_q  <= '0;
      connect_q   <= 1'b0;
      listen_q    <= 1'b0;
      connected_q <= 1'b0;
      peer_ipv4_q <= '0;
      peer_port_q <= '0;
      attempts_q  <= 8'd0;
      give_up_q   <= 1'b0;
      seen_open_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      server_q    <= server_d;
      rem_ipv4_q  <= rem_ipv4_d;
      rem_port_q  <= rem_port_d;
      loc_port_q  <= loc_port_d;
      connect_q   <= connect_d;
      listen_q    <= listen_d;
      connected_q <= connected_d;
      peer_ipv4_q <= peer_ipv4_d;
      peer_port_q <= peer_port_d;
      attempts_q  <= attempts_d;
      give_up_q   <= give_up_d;
      seen_open_q <= seen_open_d;
    end
  end

  assign ctl.connect  = connect_q;
  assign ctl.listen   = listen_q;
  assign ctl.rem_ipv4 = rem_ipv4_q;
  assign ctl.rem_port = rem_port_q;
  assign ctl.loc_port = loc_port_q;

  assign connected = connected_q;
  assign peer_ipv4 = peer_ipv4_q;
  assign peer_port = peer_port_q;
  assign attempts  = attempts_q;
  assign give_up   = give_up_q;

endmodule
`default_nettype wire

// File: tb/tb_tcp_con_mgr.sv
`default_nettype none
// ============================================================================
// Module      : tb_tcp_con_mgr
// Description : Self-checking bench for tcp_con_mgr. The engine side of the
//               control interface is driven directly; expected timings are
//               derived from the parameters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tcp_con_mgr;
  import tcp_vlg_pkg::*;

  localparam int T = 100;   // attempt timeout
  localparam int B = 20;    // back-off
  localparam int R = 3;     // retry limit

  // Reference timing, in clocks, derived from the behavioural rules:
  //  - en is seen by IDLE, one ARM cycle follows, then the request level is
  //    visible: 2 clocks from en to connect/listen.
  //  - an attempt window lasts TIMEOUT clocks.
  //  - between windows: BACKOFF clocks idle plus the ARM cycle.
  //  - give_up rises BACKOFF clocks after the last window closes.
  //  - connected follows the established status by one clock.
  localparam int LAT_EN  = 2;
  localparam int WIN_HI  = T;
  localparam int GAP_LO  = B + 1;
  localparam int GU_LAT  = B;
  localparam int UP_LAT  = 1;

  localparam int S_CON = 0;
  localparam int S_LIS = 1;
  localparam int S_UP  = 2;
  localparam int S_GU  = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       server;
  ipv4_t      cfg_rem_ipv4;
  port_t      cfg_rem_port;
  port_t      cfg_loc_port;
  logic       connected;
  ipv4_t      peer_ipv4;
  port_t      peer_port;
  logic [7:0] attempts;
  logic       give_up;

  int n_chk  = 0;
  int n_pass = 0;

  tcp_ctl_ifc ctl_if ();

  tcp_con_mgr #(
    .TIMEOUT_TICKS (T),
    .BACKOFF_TICKS (B),
    .MAX_RETRIES   (R),
    .CNT_W         (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .server       (server),
    .cfg_rem_ipv4 (cfg_rem_ipv4),
    .cfg_rem_port (cfg_rem_port),
    .cfg_loc_port (cfg_loc_port),
    .ctl          (ctl_if),
    .connected    (connected),
    .peer_ipv4    (peer_ipv4),
    .peer_port    (peer_port),
    .attempts     (attempts),
    .give_up      (give_up)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic sig(input int which);
    case (which)
      S_CON:   return ctl_if.connect;
      S_LIS:   return ctl_if.listen;
      S_UP:    return connected;
      default: return give_up;
    endcase
  endfunction

  // Clocks until the selected signal reaches lvl; returns max on expiry.
  task automatic wait_sig(input int which, input logic lvl, input int max, output int n);
    n = 0;
    while (sig(which) !== lvl && n < max) begin
      tick(1);
      n++;
    end
  endtask

  initial begin
    ipv4_t ip_a, ip_b, ip_p;
    port_t rp_a, rp_b, lp_a, lp_b, pp;
    int    n, d, drops, exp_att;

    rst = 1'b1; en = 1'b0; server = 1'b0;
    cfg_rem_ipv4 = '0; cfg_rem_port = '0; cfg_loc_port = '0;
    ctl_if.status = tcp_closed; ctl_if.con_ipv4 = '0; ctl_if.con_port = '0;
    tick(3);
    chk("rst_connect",   ctl_if.connect,  0);
    chk("rst_listen",    ctl_if.listen,   0);
    chk("rst_rem_ipv4",  ctl_if.rem_ipv4, 0);
    chk("rst_connected", connected,       0);
    chk("rst_attempts",  attempts,        0);
    chk("rst_give_up",   give_up,         0);
    rst = 1'b0;
    tick(2);

    // ---- client connect, established after a random delay ----
    ip_a = $urandom; rp_a = 16'($urandom); lp_a = 16'($urandom);
    cfg_rem_ipv4 = ip_a; cfg_rem_port = rp_a; cfg_loc_port = lp_a;
    en = 1'b1;
    exp_att = 1;
    wait_sig(S_CON, 1'b1, 10, n);
    chk("cli_lat",      n,               LAT_EN);
    chk("cli_attempts", attempts,        exp_att);
    chk("cli_rem_ipv4", ctl_if.rem_ipv4, ip_a);
    chk("cli_rem_port", ctl_if.rem_port, rp_a);
    chk("cli_loc_port", ctl_if.loc_port, lp_a);
    ctl_if.status = tcp_syn_sent;
    d = $urandom_range(3, 60);
    tick(d);
    chk("cli_not_up", connected, 0);
    ip_p = $urandom; pp = 16'($urandom);
    ctl_if.con_ipv4 = ip_p; ctl_if.con_port = pp;
    ctl_if.status = tcp_established;
    wait_sig(S_UP, 1'b1, 5, n);
    chk("cli_up_lat",    n,              UP_LAT);
    chk("cli_peer_ipv4", peer_ipv4,      ip_p);
    chk("cli_peer_port", peer_port,      pp);
    chk("cli_up_conn",   ctl_if.connect, 1);

    // ---- connection drops, back-off then re-arm ----
    ctl_if.status = tcp_closed;
    tick(1);
    chk("drop_connected", connected,      0);
    chk("drop_connect",   ctl_if.connect, 0);
    wait_sig(S_CON, 1'b1, B + 10, n);
    exp_att++;
    chk("drop_gap",      n,        GAP_LO);
    chk("drop_attempts", attempts, exp_att);

    // ---- en=0 mid-WAIT with cfg changed; en beats same-cycle established ----
    ip_b = $urandom; rp_b = 16'($urandom); lp_b = 16'($urandom);
    cfg_rem_ipv4 = ip_b; cfg_rem_port = rp_b; cfg_loc_port = lp_b;
    en = 1'b0;
    ctl_if.status = tcp_established;
    tick(1);
    chk("dis_connect",   ctl_if.connect, 0);
    chk("dis_connected", connected,      0);
    chk("dis_attempts",  attempts,       0);
    ctl_if.status = tcp_closed;
    en = 1'b1;
    wait_sig(S_CON, 1'b1, 10, n);
    chk("reen_lat",      n,               LAT_EN);
    chk("reen_rem_ipv4", ctl_if.rem_ipv4, ip_b);
    chk("reen_rem_port", ctl_if.rem_port, rp_b);
    chk("reen_loc_port", ctl_if.loc_port, lp_b);

    // ---- rst mid-WAIT with cfg changed ----
    rp_a = 16'($urandom);
    cfg_rem_port = rp_a;
    rst = 1'b1;
    tick(1);
    chk("rstw_connect",  ctl_if.connect, 0);
    chk("rstw_attempts", attempts,       0);
    rst = 1'b0;
    wait_sig(S_CON, 1'b1, 10, n);
    chk("rstw_lat",      n,               LAT_EN);
    chk("rstw_rem_port", ctl_if.rem_port, rp_a);
    exp_att = 1;

    // ---- engine leaves closed then returns: failed attempt ----
    ctl_if.status = tcp_syn_sent;
    tick(2);
    ctl_if.status = tcp_closed;
    tick(1);
    chk("refused_connect", ctl_if.connect, 0);
    wait_sig(S_CON, 1'b1, B + 10, n);
    exp_att++;
    chk("refused_gap",      n,        GAP_LO);
    chk("refused_attempts", attempts, exp_att);

    // ---- established on the same clock as the timeout ----
    tick(T - 1);
    chk("edge_still_conn", ctl_if.connect, 1);
    ctl_if.con_ipv4 = ip_a; ctl_if.con_port = rp_b;
    ctl_if.status = tcp_established;
    tick(1);
    chk("edge_connected", connected,      1);
    chk("edge_connect",   ctl_if.connect, 1);
    chk("edge_peer_ipv4", peer_ipv4,      ip_a);

    // ---- never established: R windows, then give up ----
    en = 1'b0;
    ctl_if.status = tcp_closed;
    tick(2);
    en = 1'b1;
    for (int w = 1; w <= R; w++) begin
      wait_sig(S_CON, 1'b1, B + 10, n);
      chk("retry_rise", n, (w == 1) ? LAT_EN : GAP_LO);
      chk("retry_attempts", attempts, w);
      wait_sig(S_CON, 1'b0, T + 10, n);
      chk("retry_window", n, WIN_HI);
    end
    wait_sig(S_GU, 1'b1, B + 10, n);
    chk("giveup_lat", n, GU_LAT);
    tick(3 * (T + B));
    chk("hold_connect",  ctl_if.connect, 0);
    chk("hold_give_up",  give_up,        1);
    chk("hold_attempts", attempts,       R);
    en = 1'b0;
    tick(1);
    chk("release_give_up",  give_up,  0);
    chk("release_attempts", attempts, 0);

    // ---- server listen: no timeout, long wait ----
    server = 1'b1;
    cfg_loc_port = 16'h1F90;
    cfg_rem_ipv4 = $urandom; cfg_rem_port = 16'($urandom);
    en = 1'b1;
    wait_sig(S_LIS, 1'b1, 10, n);
    chk("srv_lat",      n,               LAT_EN);
    chk("srv_connect",  ctl_if.connect,  0);
    chk("srv_loc_port", ctl_if.loc_port, 16'h1F90);
    ctl_if.status = tcp_listen;
    drops = 0;
    d = 10000 + $urandom_range(0, 500);
    for (int i = 0; i < d; i++) begin
      tick(1);
      if (ctl_if.listen !== 1'b1 || ctl_if.loc_port !== 16'h1F90) drops++;
    end
    chk("srv_hold", drops, 0);
    ip_p = $urandom; pp = 16'($urandom);
    ctl_if.con_ipv4 = ip_p; ctl_if.con_port = pp;
    ctl_if.status = tcp_established;
    wait_sig(S_UP, 1'b1, 5, n);
    chk("srv_up_lat",    n,             UP_LAT);
    chk("srv_peer_ipv4", peer_ipv4,     ip_p);
    chk("srv_peer_port", peer_port,     pp);
    chk("srv_listen_up", ctl_if.listen, 1);
    chk("srv_attempts",  attempts,      1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
